sr_trace_buffer: RTL

- Retire-trace capture buffer that sits directly downstream of the schoolRISCV core, beside sm_top.
- Samples one record per retired instruction (pc, instr, register write) into a circular RAM.
- Stops a programmable number of records after a PC-match or external trigger.
- Exposes the frozen history through a random-access read port, for simulation dumps and board debug.

---
 rtl/sr_trace_pkg.sv | 40 ++++
 rtl/sr_trace_ram.sv | 35 +++
 rtl/sr_trace_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sr_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_trace_pkg
//  Description : Shared definitions for the schoolRISCV retire-trace buffer:
//                FSM state encodings, record field offsets/width, cycle-stamp
//                width and a record packing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sr_trace_pkg;

  typedef enum logic [1:0] {
    SR_TRACE_IDLE      = 2'd0,
    SR_TRACE_ARMED     = 2'd1,
    SR_TRACE_TRIGGERED = 2'd2,
    SR_TRACE_DONE      = 2'd3
  } sr_trace_state_e;

  // Record layout, MSB first: {pc, instr, we, rd, wdata}
  localparam int SR_TRACE_WDATA_LSB = 0;
  localparam int SR_TRACE_RD_LSB    = 32;
  localparam int SR_TRACE_WE_BIT    = 37;
  localparam int SR_TRACE_INSTR_LSB = 38;
  localparam int SR_TRACE_PC_LSB    = 70;
  localparam int SR_TRACE_REC_W     = 102;

  // Width of the optional free-running cycle stamp
  localparam int SR_TRACE_CYC_W     = 16;

  function automatic logic [SR_TRACE_REC_W-1:0] sr_trace_pack(
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic        we,
    input logic [4:0]  rd,
    input logic [31:0] wdata
  );
    return {pc, instr, we, rd, wdata};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_trace_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sr_trace_ram
//  Description : DEPTH x W simple dual-port RAM. Synchronous write, registered
//                synchronous read; a read colliding with a write to the same
//                entry returns the old contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 102,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Write and read in one process so a same-address read sees pre-write data
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sr_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sr_trace_buffer
//  Description : Retire-trace capture buffer for the schoolRISCV core. Records
//                one entry per retired instruction into a circular RAM, stops
//                POST_TRIG records after a PC-match or external trigger and
//                exposes the frozen history through a random-access read port.
//                Optional feature macro: SR_TRACE_CYCLE_EN adds a 16-bit cycle
//                stamp to every record and the rd_cycle output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_trace_buffer
  import sr_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tr_valid,
  input  logic [31:0]               tr_pc,
  input  logic [31:0]               tr_instr,
  input  logic                      tr_we,
  input  logic [4:0]                tr_rd,
  input  logic [31:0]               tr_wdata,
  input  logic                      arm,
  input  logic                      trig_pc_en,
  input  logic [31:0]               trig_pc,
  input  logic                      trig_ext,
  input  logic [AW-1:0]             rd_addr,
  input  logic                      rd_req,
  output logic                      rd_valid,
  output logic [SR_TRACE_REC_W-1:0] rd_data,
  output logic                      rd_err,
  output logic [1:0]                state,
  output logic [AW:0]               count,
  output logic                      done
`ifdef SR_TRACE_CYCLE_EN
  ,
  output logic [SR_TRACE_CYC_W-1:0] rd_cycle
`endif
);

`ifdef SR_TRACE_CYCLE_EN
  localparam int RAM_W = SR_TRACE_REC_W + SR_TRACE_CYC_W;
`else
  localparam int RAM_W = SR_TRACE_REC_W;
`endif

  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] C_POST = AW'(POST_TRIG);

  sr_trace_state_e state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   post_q, post_d;
  logic            rd_valid_q, rd_err_q;

  logic            w_capture;
  logic            w_trig_hit;
  logic [AW-1:0]   w_oldest;
  logic [AW-1:0]   w_raddr;
  logic            w_addr_err;
  logic [RAM_W-1:0] w_ram_wdata;
  logic [RAM_W-1:0] w_ram_rdata;

  // Capture only while armed or triggered; the arm cycle itself never captures
  assign w_capture  = tr_valid && !arm &&
                      (state_q == SR_TRACE_ARMED || state_q == SR_TRACE_TRIGGERED);
  assign w_trig_hit = (tr_valid && trig_pc_en && (tr_pc == trig_pc)) || trig_ext;

`ifdef SR_TRACE_CYCLE_EN
  logic [SR_TRACE_CYC_W-1:0] cyc_q;

  // Free-running cycle stamp, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_q + 1'b1;
  end

  assign w_ram_wdata = {cyc_q, sr_trace_pack(tr_pc, tr_instr, tr_we, tr_rd, tr_wdata)};
`else
  assign w_ram_wdata = sr_trace_pack(tr_pc, tr_instr, tr_we, tr_rd, tr_wdata);
`endif

  // Next-state logic: arm dominates, then capture bookkeeping and trigger handling
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    post_d  = post_q;
    if (arm) begin
      state_d = SR_TRACE_ARMED;
      wptr_d  = '0;
      count_d = '0;
      post_d  = '0;
    end else begin
      if (w_capture) begin
        wptr_d = wptr_q + 1'b1;
        if (count_q != C_FULL) count_d = count_q + 1'b1;
      end
      case (state_q)
        SR_TRACE_ARMED: begin
          if (w_trig_hit) begin
            post_d  = C_POST;
            state_d = (POST_TRIG == 0) ? SR_TRACE_DONE : SR_TRACE_TRIGGERED;
          end
        end
        SR_TRACE_TRIGGERED: begin
          // The trigger record itself is not counted; only later captures are
          if (w_capture) begin
            post_d = post_q - 1'b1;
            if (post_q == AW'(1)) state_d = SR_TRACE_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SR_TRACE_IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      post_q  <= post_d;
    end
  end

  // Logical index 0 is the oldest record: the write pointer once the buffer has wrapped
  assign w_oldest   = (count_q == C_FULL) ? wptr_q : '0;
  assign w_raddr    = w_oldest + rd_addr;
  assign w_addr_err = ({1'b0, rd_addr} >= count_q);

  // Read handshake flags, aligned with the registered RAM output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      rd_err_q   <= rd_req && w_addr_err;
    end
  end

  sr_trace_ram #(
    .DEPTH (DEPTH),
    .W     (RAM_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_capture),
    .waddr_i (wptr_q),
    .wdata_i (w_ram_wdata),
    .re_i    (rd_req),
    .raddr_i (w_raddr),
    .rdata_o (w_ram_rdata)
  );

  // Data is forced to zero outside a good read, which also covers reset
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = (rd_valid_q && !rd_err_q) ? w_ram_rdata[SR_TRACE_REC_W-1:0] : '0;
`ifdef SR_TRACE_CYCLE_EN
  assign rd_cycle = (rd_valid_q && !rd_err_q) ? w_ram_rdata[RAM_W-1:SR_TRACE_REC_W] : '0;
`endif
  assign state    = state_q;
  assign count    = count_q;
  assign done     = (state_q == SR_TRACE_DONE);

endmodule
`default_nettype wire
